// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Execute stage of the in-order RV32I core. Runs the ALU
//                operation selected by exe_fun, resolves conditional branches
//                and jumps into a one-cycle redirect (br_flg/br_target),
//                squashes the single wrong-path instruction that follows a
//                redirect, and registers the result bundle for the
//                memory/writeback stage.
//
//  Build option: EXE_SHIFT_ITER_EN
//                  defined   - SLL/SRL/SRA with a non-zero shift amount run
//                              through a one-bit-per-cycle shifter; decode
//                              is held off through stall_req meanwhile.
//                  undefined - single-cycle barrel shifter, stall_req = 0.
//
//  Ports
//    clk, reset                 clock, synchronous active-high reset
//    reg_pc, imm_b_sext         PC and B-immediate of incoming instruction
//    exe_fun                    ALU / branch function code
//    op1_data, op2_data         ALU operands
//    rs2_data                   store data
//    mem_wen .. inst_is_ecall   control bundle passed through
//    stall_flg                  downstream stall, freezes this stage
//    out_*, alu_out             registered result bundle
//    br_flg, br_target          registered fetch redirect
//    stall_req                  combinational hold request to decode
//
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_pc,
    input  logic [31:0] imm_b_sext,
    input  logic [4:0]  exe_fun,
    input  logic [31:0] op1_data,
    input  logic [31:0] op2_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  mem_wen,
    input  logic        rf_wen,
    input  logic [3:0]  wb_sel,
    input  logic [4:0]  wb_addr,
    input  logic [2:0]  csr_cmd,
    input  logic        jmp_flg,
    input  logic        inst_is_ecall,
    input  logic        stall_flg,
    output logic [31:0] out_reg_pc,
    output logic [31:0] alu_out,
    output logic [31:0] out_rs2_data,
    output logic [4:0]  out_mem_wen,
    output logic        out_rf_wen,
    output logic [3:0]  out_wb_sel,
    output logic [4:0]  out_wb_addr,
    output logic [2:0]  out_csr_cmd,
    output logic        out_inst_is_ecall,
    output logic        br_flg,
    output logic [31:0] br_target,
    output logic        stall_req
);

    // ------------------------------------------------------------------
    // Function encodings
    // ------------------------------------------------------------------
    localparam logic [4:0] c_ALU_X     = 5'd0;
    localparam logic [4:0] c_ALU_ADD   = 5'd1;
    localparam logic [4:0] c_ALU_SUB   = 5'd2;
    localparam logic [4:0] c_ALU_AND   = 5'd3;
    localparam logic [4:0] c_ALU_OR    = 5'd4;
    localparam logic [4:0] c_ALU_XOR   = 5'd5;
    localparam logic [4:0] c_ALU_SLL   = 5'd6;
    localparam logic [4:0] c_ALU_SRL   = 5'd7;
    localparam logic [4:0] c_ALU_SRA   = 5'd8;
    localparam logic [4:0] c_ALU_SLT   = 5'd9;
    localparam logic [4:0] c_ALU_SLTU  = 5'd10;
    localparam logic [4:0] c_BR_BEQ    = 5'd11;
    localparam logic [4:0] c_BR_BNE    = 5'd12;
    localparam logic [4:0] c_BR_BLT    = 5'd13;
    localparam logic [4:0] c_BR_BGE    = 5'd14;
    localparam logic [4:0] c_BR_BLTU   = 5'd15;
    localparam logic [4:0] c_BR_BGEU   = 5'd16;
    localparam logic [4:0] c_ALU_JALR  = 5'd17;
    localparam logic [4:0] c_ALU_COPY1 = 5'd18;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic        r_squash;

`ifdef EXE_SHIFT_ITER_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [4:0]  r_sh_fun;
    logic [31:0] r_sh_val;
    logic [31:0] r_sh_pc;
    logic [31:0] r_sh_rs2;
    logic [4:0]  r_sh_mem_wen;
    logic        r_sh_rf_wen;
    logic [3:0]  r_sh_wb_sel;
    logic [4:0]  r_sh_wb_addr;
    logic [2:0]  r_sh_csr_cmd;
    logic        r_sh_ecall;

    logic        w_is_shift;
    logic        w_shift_start;
    logic [31:0] w_sh_step;
`endif

    logic [31:0] w_alu_result;
    logic        w_br_taken;
    logic        w_redirect;
    logic [31:0] w_redirect_target;

    logic [31:0] w_nxt_pc;
    logic [31:0] w_nxt_alu;
    logic [31:0] w_nxt_rs2;
    logic [4:0]  w_nxt_mem_wen;
    logic        w_nxt_rf_wen;
    logic [3:0]  w_nxt_wb_sel;
    logic [4:0]  w_nxt_wb_addr;
    logic [2:0]  w_nxt_csr_cmd;
    logic        w_nxt_ecall;
    logic        w_nxt_br_flg;
    logic [31:0] w_nxt_br_target;
    logic        w_nxt_squash;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_result = 32'd0;
        case (exe_fun)
            c_ALU_X:     w_alu_result = 32'd0;
            c_ALU_ADD:   w_alu_result = op1_data + op2_data;
            c_ALU_SUB:   w_alu_result = op1_data - op2_data;
            c_ALU_AND:   w_alu_result = op1_data & op2_data;
            c_ALU_OR:    w_alu_result = op1_data | op2_data;
            c_ALU_XOR:   w_alu_result = op1_data ^ op2_data;
`ifdef EXE_SHIFT_ITER_EN
            // Only reached with a zero shift amount; any other amount is
            // handed to the iterative shifter instead.
            c_ALU_SLL,
            c_ALU_SRL,
            c_ALU_SRA:   w_alu_result = op1_data;
`else
            c_ALU_SLL:   w_alu_result = op1_data << op2_data[4:0];
            c_ALU_SRL:   w_alu_result = op1_data >> op2_data[4:0];
            c_ALU_SRA:   w_alu_result = $unsigned($signed(op1_data) >>> op2_data[4:0]);
`endif
            c_ALU_SLT:   w_alu_result = {31'd0, $signed(op1_data) < $signed(op2_data)};
            c_ALU_SLTU:  w_alu_result = {31'd0, op1_data < op2_data};
            c_ALU_JALR:  w_alu_result = (op1_data + op2_data) & ~32'd1;
            c_ALU_COPY1: w_alu_result = op1_data;
            default:     w_alu_result = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    always_comb begin
        w_br_taken = 1'b0;
        case (exe_fun)
            c_BR_BEQ:  w_br_taken = (op1_data == op2_data);
            c_BR_BNE:  w_br_taken = (op1_data != op2_data);
            c_BR_BLT:  w_br_taken = ($signed(op1_data) <  $signed(op2_data));
            c_BR_BGE:  w_br_taken = ($signed(op1_data) >= $signed(op2_data));
            c_BR_BLTU: w_br_taken = (op1_data <  op2_data);
            c_BR_BGEU: w_br_taken = (op1_data >= op2_data);
            default:   w_br_taken = 1'b0;
        endcase
    end

    assign w_redirect        = w_br_taken | jmp_flg;
    assign w_redirect_target = w_br_taken ? (reg_pc + imm_b_sext) :
                               (jmp_flg ? w_alu_result : 32'd0);

`ifdef EXE_SHIFT_ITER_EN
    // ------------------------------------------------------------------
    // Iterative shifter support
    // ------------------------------------------------------------------
    assign w_is_shift    = (exe_fun == c_ALU_SLL) || (exe_fun == c_ALU_SRL) ||
                           (exe_fun == c_ALU_SRA);
    assign w_shift_start = (r_state == S_IDLE) && !r_squash && w_is_shift &&
                           (op2_data[4:0] != 5'd0);

    always_comb begin
        case (r_sh_fun)
            c_ALU_SLL: w_sh_step = {r_sh_val[30:0], 1'b0};
            c_ALU_SRL: w_sh_step = {1'b0, r_sh_val[31:1]};
            default:   w_sh_step = {r_sh_val[31], r_sh_val[31:1]};
        endcase
    end

    // Hold decode from the capture cycle until the last shift step; on the
    // final step decode may advance because its inputs are ignored here.
    assign stall_req = !reset &&
                       (((r_state == S_IDLE) && w_shift_start && !stall_flg) ||
                        ((r_state == S_SHIFT) && (r_count != 5'd1)));
`else
    assign stall_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next registered bundle (all-zero defaults form a bubble)
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_pc        = 32'd0;
        w_nxt_alu       = 32'd0;
        w_nxt_rs2       = 32'd0;
        w_nxt_mem_wen   = 5'd0;
        w_nxt_rf_wen    = 1'b0;
        w_nxt_wb_sel    = 4'd0;
        w_nxt_wb_addr   = 5'd0;
        w_nxt_csr_cmd   = 3'd0;
        w_nxt_ecall     = 1'b0;
        w_nxt_br_flg    = 1'b0;
        w_nxt_br_target = 32'd0;
        w_nxt_squash    = r_squash;
`ifdef EXE_SHIFT_ITER_EN
        if (r_state == S_SHIFT) begin
            if (r_count == 5'd1) begin
                w_nxt_pc      = r_sh_pc;
                w_nxt_alu     = w_sh_step;
                w_nxt_rs2     = r_sh_rs2;
                w_nxt_mem_wen = r_sh_mem_wen;
                w_nxt_rf_wen  = r_sh_rf_wen;
                w_nxt_wb_sel  = r_sh_wb_sel;
                w_nxt_wb_addr = r_sh_wb_addr;
                w_nxt_csr_cmd = r_sh_csr_cmd;
                w_nxt_ecall   = r_sh_ecall;
            end
        end else
`endif
        if (r_squash) begin
            // Wrong-path instruction behind a redirect: drop it.
            w_nxt_squash = 1'b0;
        end
`ifdef EXE_SHIFT_ITER_EN
        else if (w_shift_start) begin
            w_nxt_squash = 1'b0;
        end
`endif
        else begin
            w_nxt_pc        = reg_pc;
            w_nxt_alu       = w_br_taken ? 32'd0 : w_alu_result;
            w_nxt_rs2       = rs2_data;
            w_nxt_mem_wen   = mem_wen;
            w_nxt_rf_wen    = rf_wen;
            w_nxt_wb_sel    = wb_sel;
            w_nxt_wb_addr   = wb_addr;
            w_nxt_csr_cmd   = csr_cmd;
            w_nxt_ecall     = inst_is_ecall;
            w_nxt_br_flg    = w_redirect;
            w_nxt_br_target = w_redirect_target;
            w_nxt_squash    = w_redirect;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers and shifter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg_pc        <= 32'd0;
            alu_out           <= 32'd0;
            out_rs2_data      <= 32'd0;
            out_mem_wen       <= 5'd0;
            out_rf_wen        <= 1'b0;
            out_wb_sel        <= 4'd0;
            out_wb_addr       <= 5'd0;
            out_csr_cmd       <= 3'd0;
            out_inst_is_ecall <= 1'b0;
            br_flg            <= 1'b0;
            br_target         <= 32'd0;
            r_squash          <= 1'b0;
`ifdef EXE_SHIFT_ITER_EN
            r_state           <= S_IDLE;
            r_count           <= 5'd0;
            r_sh_fun          <= 5'd0;
            r_sh_val          <= 32'd0;
            r_sh_pc           <= 32'd0;
            r_sh_rs2          <= 32'd0;
            r_sh_mem_wen      <= 5'd0;
            r_sh_rf_wen       <= 1'b0;
            r_sh_wb_sel       <= 4'd0;
            r_sh_wb_addr      <= 5'd0;
            r_sh_csr_cmd      <= 3'd0;
            r_sh_ecall        <= 1'b0;
`endif
        end else if (!stall_flg) begin
            out_reg_pc        <= w_nxt_pc;
            alu_out           <= w_nxt_alu;
            out_rs2_data      <= w_nxt_rs2;
            out_mem_wen       <= w_nxt_mem_wen;
            out_rf_wen        <= w_nxt_rf_wen;
            out_wb_sel        <= w_nxt_wb_sel;
            out_wb_addr       <= w_nxt_wb_addr;
            out_csr_cmd       <= w_nxt_csr_cmd;
            out_inst_is_ecall <= w_nxt_ecall;
            br_flg            <= w_nxt_br_flg;
            br_target         <= w_nxt_br_target;
            r_squash          <= w_nxt_squash;
`ifdef EXE_SHIFT_ITER_EN
            case (r_state)
                S_IDLE: begin
                    if (w_shift_start) begin
                        r_state      <= S_SHIFT;
                        r_count      <= op2_data[4:0];
                        r_sh_fun     <= exe_fun;
                        r_sh_val     <= op1_data;
                        r_sh_pc      <= reg_pc;
                        r_sh_rs2     <= rs2_data;
                        r_sh_mem_wen <= mem_wen;
                        r_sh_rf_wen  <= rf_wen;
                        r_sh_wb_sel  <= wb_sel;
                        r_sh_wb_addr <= wb_addr;
                        r_sh_csr_cmd <= csr_cmd;
                        r_sh_ecall   <= inst_is_ecall;
                    end
                end
                S_SHIFT: begin
                    r_sh_val <= w_sh_step;
                    r_count  <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
module tb_execute_stage;

    localparam logic [4:0] c_ALU_X     = 5'd0;
    localparam logic [4:0] c_ALU_ADD   = 5'd1;
    localparam logic [4:0] c_ALU_SUB   = 5'd2;
    localparam logic [4:0] c_ALU_AND   = 5'd3;
    localparam logic [4:0] c_ALU_OR    = 5'd4;
    localparam logic [4:0] c_ALU_XOR   = 5'd5;
    localparam logic [4:0] c_ALU_SLL   = 5'd6;
    localparam logic [4:0] c_ALU_SRL   = 5'd7;
    localparam logic [4:0] c_ALU_SRA   = 5'd8;
    localparam logic [4:0] c_ALU_SLT   = 5'd9;
    localparam logic [4:0] c_ALU_SLTU  = 5'd10;
    localparam logic [4:0] c_BR_BEQ    = 5'd11;
    localparam logic [4:0] c_BR_BNE    = 5'd12;
    localparam logic [4:0] c_BR_BLT    = 5'd13;
    localparam logic [4:0] c_BR_BGE    = 5'd14;
    localparam logic [4:0] c_BR_BLTU   = 5'd15;
    localparam logic [4:0] c_BR_BGEU   = 5'd16;
    localparam logic [4:0] c_ALU_JALR  = 5'd17;
    localparam logic [4:0] c_ALU_COPY1 = 5'd18;

`ifdef EXE_SHIFT_ITER_EN
    localparam bit ITER = 1'b1;
`else
    localparam bit ITER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_pc, imm_b_sext, op1_data, op2_data, rs2_data;
    logic [4:0]  exe_fun, mem_wen, wb_addr;
    logic        rf_wen, jmp_flg, inst_is_ecall, stall_flg;
    logic [3:0]  wb_sel;
    logic [2:0]  csr_cmd;
    logic [31:0] out_reg_pc, alu_out, out_rs2_data, br_target;
    logic [4:0]  out_mem_wen, out_wb_addr;
    logic        out_rf_wen, out_inst_is_ecall, br_flg, stall_req;
    logic [3:0]  out_wb_sel;
    logic [2:0]  out_csr_cmd;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset), .reg_pc(reg_pc), .imm_b_sext(imm_b_sext),
        .exe_fun(exe_fun), .op1_data(op1_data), .op2_data(op2_data),
        .rs2_data(rs2_data), .mem_wen(mem_wen), .rf_wen(rf_wen),
        .wb_sel(wb_sel), .wb_addr(wb_addr), .csr_cmd(csr_cmd),
        .jmp_flg(jmp_flg), .inst_is_ecall(inst_is_ecall), .stall_flg(stall_flg),
        .out_reg_pc(out_reg_pc), .alu_out(alu_out), .out_rs2_data(out_rs2_data),
        .out_mem_wen(out_mem_wen), .out_rf_wen(out_rf_wen), .out_wb_sel(out_wb_sel),
        .out_wb_addr(out_wb_addr), .out_csr_cmd(out_csr_cmd),
        .out_inst_is_ecall(out_inst_is_ecall), .br_flg(br_flg),
        .br_target(br_target), .stall_req(stall_req)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] tgt;
        logic [4:0]  mem_wen;
        logic        rf_wen;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
        logic [2:0]  csr;
        logic        ecall;
        logic        br;
    } exp_t;

    typedef struct {
        logic [31:0] pc, imm, op1, op2, rs2;
        logic [4:0]  fun, mem_wen, wb_addr;
        logic        rf_wen, jmp, ecall;
        logic [3:0]  wb_sel;
        logic [2:0]  csr;
    } ins_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad = 0;
    bit   sqm = 1'b0;   // model: next instruction lies on the wrong path

    // ---------------- reference model ----------------
    function automatic exp_t model(input ins_t x);
        exp_t        e;
        logic [31:0] a;
        logic        taken;
        int          sh;
        e = '0;
        a = 32'd0;
        taken = 1'b0;
        sh = int'(x.op2 % 32);
        case (x.fun)
            c_ALU_X:     a = 32'd0;
            c_ALU_ADD:   a = x.op1 + x.op2;
            c_ALU_SUB:   a = x.op1 - x.op2;
            c_ALU_AND:   a = x.op1 & x.op2;
            c_ALU_OR:    a = x.op1 | x.op2;
            c_ALU_XOR:   a = x.op1 ^ x.op2;
            c_ALU_SLL:   a = x.op1 << sh;
            c_ALU_SRL:   a = x.op1 >> sh;
            c_ALU_SRA:   a = (x.op1 >> sh) | ((x.op1 >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            c_ALU_SLT:   a = (int'(x.op1) < int'(x.op2)) ? 32'd1 : 32'd0;
            c_ALU_SLTU:  a = (x.op1 < x.op2) ? 32'd1 : 32'd0;
            c_ALU_JALR:  a = (x.op1 + x.op2) & 32'hFFFF_FFFE;
            c_ALU_COPY1: a = x.op1;
            c_BR_BEQ:    taken = (x.op1 == x.op2);
            c_BR_BNE:    taken = (x.op1 != x.op2);
            c_BR_BLT:    taken = (int'(x.op1) <  int'(x.op2));
            c_BR_BGE:    taken = (int'(x.op1) >= int'(x.op2));
            c_BR_BLTU:   taken = (x.op1 <  x.op2);
            c_BR_BGEU:   taken = (x.op1 >= x.op2);
            default:     a = 32'd0;
        endcase
        e.pc = x.pc; e.alu = a; e.rs2 = x.rs2; e.mem_wen = x.mem_wen;
        e.rf_wen = x.rf_wen; e.wb_sel = x.wb_sel; e.wb_addr = x.wb_addr;
        e.csr = x.csr; e.ecall = x.ecall;
        e.br  = taken | x.jmp;
        e.tgt = taken ? (x.pc + x.imm) : (x.jmp ? a : 32'd0);
        return e;
    endfunction

    function automatic bit is_shift(input logic [4:0] f);
        return (f == c_ALU_SLL) || (f == c_ALU_SRL) || (f == c_ALU_SRA);
    endfunction

    function automatic ins_t mk(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm, input logic j);
        ins_t x;
        x.fun = f; x.op1 = a; x.op2 = b; x.pc = pc; x.imm = imm; x.jmp = j;
        x.rs2 = $urandom; x.mem_wen = 5'($urandom); x.rf_wen = 1'b1;
        x.wb_sel = 4'($urandom); x.wb_addr = 5'($urandom); x.csr = 3'($urandom);
        x.ecall = 1'($urandom);
        return x;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t x;
        logic [4:0] f;
        logic       j;
        f = 5'($urandom_range(0, 20));
        j = ((f == c_ALU_ADD) || (f == c_ALU_JALR)) && ($urandom_range(0, 3) == 0);
        x = mk(f, rand_op(), rand_op(), $urandom, $urandom, j);
        if ($urandom_range(0, 3) == 0) x.op2 = x.op1;
        x.rf_wen = 1'($urandom);
        return x;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_ins(input ins_t x);
        reg_pc = x.pc; imm_b_sext = x.imm; exe_fun = x.fun; op1_data = x.op1;
        op2_data = x.op2; rs2_data = x.rs2; mem_wen = x.mem_wen; rf_wen = x.rf_wen;
        wb_sel = x.wb_sel; wb_addr = x.wb_addr; csr_cmd = x.csr; jmp_flg = x.jmp;
        inst_is_ecall = x.ecall;
    endtask

    task automatic drive_garbage();
        drive_ins(rand_ins());
    endtask

    // Called at a negedge; returns at a negedge. Pushes the expected bundles
    // for this instruction and occupies as many non-stalled edges as it needs.
    task automatic issue(input ins_t x, input int stall_pct, input int max_edges);
        exp_t seq[$];
        exp_t e;
        int   n;
        bit   st;
        bit   want_sr;
        if (sqm) begin
            seq.push_back('0);
            sqm = 1'b0;
        end else if (ITER && is_shift(x.fun) && (x.op2 % 32 != 0)) begin
            repeat (int'(x.op2 % 32)) seq.push_back('0);
            seq.push_back(model(x));
        end else begin
            e = model(x);
            seq.push_back(e);
            sqm = e.br;
        end
        foreach (seq[i]) exp_q.push_back(seq[i]);
        n = 0;
        while (n < seq.size() && n < max_edges) begin
            if (n == 0) drive_ins(x); else drive_garbage();
            st = ($urandom_range(0, 99) < stall_pct);
            stall_flg = st;
            #1;
            if (!st) begin
                want_sr = (n < seq.size() - 1);
                total++;
                if (stall_req !== want_sr) begin
                    bad++;
                    $display("FAIL stall_req t=%0t got=%b want=%b", $time, stall_req, want_sr);
                end
            end
            @(negedge clk);
            if (!st) n++;
        end
    endtask

    task automatic stall_cycles(input int k);
        repeat (k) begin
            drive_garbage();
            stall_flg = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int k);
        reset = 1'b1;
        stall_flg = 1'b0;
        exp_q.delete();
        sqm = 1'b0;
        drive_ins(mk(c_ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0));
        repeat (k) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_req_after_reset got=%b want=0", stall_req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input exp_t w, input string nm);
        exp_t g;
        g.pc = out_reg_pc; g.alu = alu_out; g.rs2 = out_rs2_data; g.tgt = br_target;
        g.mem_wen = out_mem_wen; g.rf_wen = out_rf_wen; g.wb_sel = out_wb_sel;
        g.wb_addr = out_wb_addr; g.csr = out_csr_cmd; g.ecall = out_inst_is_ecall;
        g.br = br_flg;
        total++;
        if (g !== w) begin
            bad++;
            $display("FAIL %s t=%0t got pc=%h alu=%h rs2=%h br=%b tgt=%h ctl=%h_%b_%h_%h_%h_%b want pc=%h alu=%h rs2=%h br=%b tgt=%h ctl=%h_%b_%h_%h_%h_%b",
                     nm, $time, g.pc, g.alu, g.rs2, g.br, g.tgt, g.mem_wen, g.rf_wen, g.wb_sel, g.wb_addr, g.csr, g.ecall,
                     w.pc, w.alu, w.rs2, w.br, w.tgt, w.mem_wen, w.rf_wen, w.wb_sel, w.wb_addr, w.csr, w.ecall);
        end
    endtask

    initial begin
        bit r_smp, s_smp;
        last_exp = '0;
        forever begin
            @(posedge clk);
            r_smp = reset;
            s_smp = stall_flg;
            #1;
            if (r_smp) begin
                last_exp = '0;
                check(last_exp, "reset");
            end else if (!s_smp) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow t=%0t got=empty want=entry", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    check(last_exp, "bundle");
                end
            end else begin
                check(last_exp, "hold");
            end
        end
    end

    initial begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        stall_flg = 1'b0;
        drive_ins(mk(c_ALU_ADD, 32'd3, 32'd4, 32'h40, 32'd0, 1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(mk(c_ALU_ADD, 32'd3, 32'd4, 32'h40, 32'd0, 1'b0), 0, 99);

        issue(mk(c_ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'h44, 32'd0, 1'b0), 0, 99);
        issue(mk(c_ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h48, 32'd0, 1'b0), 0, 99);
        issue(mk(c_ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'h4C, 32'd0, 1'b0), 0, 99);

        issue(mk(c_BR_BEQ,  32'd5, 32'd5, 32'h100, 32'h20, 1'b0), 0, 99);
        issue(mk(c_ALU_ADD, 32'd1, 32'd2, 32'h104, 32'd0, 1'b0), 0, 99);
        issue(mk(c_ALU_ADD, 32'd1, 32'd2, 32'h120, 32'd0, 1'b0), 0, 99);

        issue(mk(c_ALU_JALR, 32'h1001, 32'd4, 32'h200, 32'd0, 1'b1), 0, 99);
        stall_cycles(3);
        issue(mk(c_ALU_ADD, 32'd9, 32'd9, 32'h204, 32'd0, 1'b0), 0, 99);
        issue(mk(c_ALU_ADD, 32'd9, 32'd9, 32'h1004, 32'd0, 1'b0), 0, 99);

        issue(mk(c_ALU_SRA, 32'h8000_0000, 32'd4, 32'h300, 32'd0, 1'b0), 0, 99);
        issue(mk(c_ALU_ADD, 32'd10, 32'd20, 32'h304, 32'd0, 1'b0), 0, 99);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) stall_cycles($urandom_range(1, 3));
            issue(rand_ins(), 20, 99);
        end

        issue(mk(c_ALU_SLL, $urandom, 32'd10, 32'h400, 32'd0, 1'b0), 0, 2);
        do_reset(2);
        issue(mk(c_ALU_ADD, 32'd100, 32'd23, 32'h500, 32'd0, 1'b0), 0, 99);
        for (int i = 0; i < 40; i++) issue(rand_ins(), 20, 99);

        stall_flg = 1'b1;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
